// File: rtl/prl_tx_arbiter.sv
// prl_tx_arbiter: USB-PD protocol-layer transmit arbiter/sequencer.
// Hard Reset, Cable Reset and SOP message requesters share one PHY transmit path.
// Grants by priority (hr > cr > msg), drives phy_req/phy_type, waits for
// ack/nack/timeout, and reports through sticky alert bits and done pulses.
// Build option: define PRL_TX_RETRY_EN to build the message retry path
// (RETRY state, retry_cnt). Without it the first message failure is final.
module prl_tx_arbiter #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int RETRY_MAX   = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        hr_req,
    input  logic        cr_req,
    input  logic        msg_req,
    input  logic        phy_ack,
    input  logic        phy_nack,
    input  logic [15:0] alert_clr,
    output logic        phy_req,
    output logic [2:0]  phy_type,
    output logic [15:0] alert,
    output logic        done_hr,
    output logic        done_cr,
    output logic        done_msg,
    output logic        busy,
    output logic [1:0]  retry_cnt
);

    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  RETRY_LIM  = 2'(RETRY_MAX);
    localparam logic [15:0] ALERT_USED = 16'h0070;
    localparam logic [15:0] AL_SUCCESS = 16'h0040;
    localparam logic [15:0] AL_DISCARD = 16'h0020;
    localparam logic [15:0] AL_FAILED  = 16'h0010;
    localparam logic [2:0]  TYPE_MSG   = 3'b000;
    localparam logic [2:0]  TYPE_HR    = 3'b101;
    localparam logic [2:0]  TYPE_CR    = 3'b110;

`ifdef PRL_TX_RETRY_EN
    localparam bit RETRY_BUILD = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RETRY, S_REPORT} state_t;
`else
    localparam bit RETRY_BUILD = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_REPORT} state_t;
`endif

    typedef enum logic [1:0] {G_HR, G_CR, G_MSG} grant_t;

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic [15:0] tmr_q, tmr_d;
    logic        phy_req_d;
    logic [2:0]  phy_type_d;
    logic [15:0] set_mask;
    logic [15:0] alert_d;
    logic        fin_d;
    logic        msg_active;
    logic        preempt;
    logic        attempt_fail;
    logic        retry_ok;
`ifdef PRL_TX_RETRY_EN
    logic [1:0]  retry_d;
`endif

    // A message transfer is preemptible while it is in REQ, WAIT or RETRY
    always_comb begin
        msg_active = 1'b0;
        if (grant_q == G_MSG) begin
            case (state_q)
                S_REQ, S_WAIT: msg_active = 1'b1;
`ifdef PRL_TX_RETRY_EN
                S_RETRY:       msg_active = 1'b1;
`endif
                default:       msg_active = 1'b0;
            endcase
        end
    end

    assign preempt      = msg_active && hr_req;
    assign attempt_fail = phy_nack || (tmr_q == TO_LAST);
    assign retry_ok     = RETRY_BUILD && (grant_q == G_MSG) && (retry_cnt < RETRY_LIM);

    // Next-state, next-output and alert update logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tmr_d      = tmr_q;
        phy_req_d  = 1'b0;
        phy_type_d = phy_type;
        set_mask   = '0;
        fin_d      = 1'b0;
`ifdef PRL_TX_RETRY_EN
        retry_d    = retry_cnt;
`endif
        case (state_q)
            S_IDLE: begin
                if (hr_req || cr_req || msg_req) begin
                    state_d = S_REQ;
`ifdef PRL_TX_RETRY_EN
                    retry_d = '0;
`endif
                    if (hr_req) begin
                        grant_d    = G_HR;
                        phy_type_d = TYPE_HR;
                    end else if (cr_req) begin
                        grant_d    = G_CR;
                        phy_type_d = TYPE_CR;
                    end else begin
                        grant_d    = G_MSG;
                        phy_type_d = TYPE_MSG;
                    end
                end
            end
            S_REQ: begin
                if (preempt) begin
                    state_d  = S_IDLE;
                    fin_d    = 1'b1;
                    set_mask = AL_DISCARD;
                end else begin
                    state_d   = S_WAIT;
                    phy_req_d = 1'b1;
                    tmr_d     = '0;
                end
            end
            S_WAIT: begin
                if (preempt) begin
                    state_d  = S_IDLE;
                    fin_d    = 1'b1;
                    set_mask = AL_DISCARD;
                end else if (phy_ack) begin
                    state_d  = S_REPORT;
                    fin_d    = 1'b1;
                    set_mask = AL_SUCCESS;
                end else if (attempt_fail) begin
                    if (retry_ok) begin
`ifdef PRL_TX_RETRY_EN
                        state_d = S_RETRY;
                        retry_d = retry_cnt + 2'd1;
`endif
                    end else begin
                        state_d  = S_REPORT;
                        fin_d    = 1'b1;
                        set_mask = AL_FAILED;
                    end
                end else begin
                    phy_req_d = 1'b1;
                    tmr_d     = tmr_q + 16'd1;
                end
            end
`ifdef PRL_TX_RETRY_EN
            S_RETRY: begin
                if (preempt) begin
                    state_d  = S_IDLE;
                    fin_d    = 1'b1;
                    set_mask = AL_DISCARD;
                end else begin
                    state_d = S_REQ;
                end
            end
`endif
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Set wins over write-1-to-clear on the same bit
        alert_d = ((alert & ~alert_clr) | set_mask) & ALERT_USED;
    end

    // State register and registered outputs
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            grant_q  <= G_MSG;
            tmr_q    <= '0;
            phy_req  <= 1'b0;
            phy_type <= TYPE_MSG;
            alert    <= '0;
            done_hr  <= 1'b0;
            done_cr  <= 1'b0;
            done_msg <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            tmr_q    <= tmr_d;
            phy_req  <= phy_req_d;
            phy_type <= phy_type_d;
            alert    <= alert_d;
            done_hr  <= fin_d && (grant_q == G_HR);
            done_cr  <= fin_d && (grant_q == G_CR);
            done_msg <= fin_d && (grant_q == G_MSG);
            busy     <= (state_d != S_IDLE);
        end
    end

`ifdef PRL_TX_RETRY_EN
    // Retries consumed by the current message; cleared on every new grant
    always_ff @(posedge CLK) begin
        if (!reset) begin
            retry_cnt <= '0;
        end else begin
            retry_cnt <= retry_d;
        end
    end
`else
    assign retry_cnt = 2'b00;
`endif

endmodule

// File: tb/tb_prl_tx_arbiter.sv
// Testbench for prl_tx_arbiter: directed scenarios followed by randomized
// request/response scenarios, checked against a transaction-level model.
module tb_prl_tx_arbiter;

    localparam int T    = 25;
    localparam int RMAX = 3;
`ifdef PRL_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        hr_req = 1'b0, cr_req = 1'b0, msg_req = 1'b0;
    logic        phy_ack = 1'b0, phy_nack = 1'b0;
    logic [15:0] alert_clr = 16'h0;
    logic        phy_req;
    logic [2:0]  phy_type;
    logic [15:0] alert;
    logic        done_hr, done_cr, done_msg, busy;
    logic [1:0]  retry_cnt;

    prl_tx_arbiter #(.TIMEOUT_CYC(T), .RETRY_MAX(RMAX)) dut (
        .CLK(CLK), .reset(reset),
        .hr_req(hr_req), .cr_req(cr_req), .msg_req(msg_req),
        .phy_ack(phy_ack), .phy_nack(phy_nack), .alert_clr(alert_clr),
        .phy_req(phy_req), .phy_type(phy_type), .alert(alert),
        .done_hr(done_hr), .done_cr(done_cr), .done_msg(done_msg),
        .busy(busy), .retry_cnt(retry_cnt)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // PHY response plan, one entry per attempt: kind 0 ack, 1 nack, 2 silent
    int resp_kind[$];
    int resp_dly[$];
    // Model expectations
    int exp_type[$];
    int exp_len[$];
    int exp_done[$];
    logic [15:0] m_alert = 16'h0;
    int exp_retry = 0;

    int hi_cnt = 0, cur_kind = 2, cur_dly = 0, cur_type = 0, n_pulses = 0;
    bit prev_req = 1'b0, acked_last = 1'b0, track = 1'b1, stray_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic log_done(input int who);
        if (track) begin
            chk("done_pending", 32'(exp_done.size() > 0), 32'd1);
            if (exp_done.size() > 0) chk("done_order", 32'(who), 32'(exp_done.pop_front()));
            if (who == 2) chk("retry_cnt", 32'(retry_cnt), 32'(exp_retry));
        end
    endtask

    task automatic attempt_end();
        if (track) begin
            chk("attempt_pending", 32'(exp_type.size() > 0), 32'd1);
            if (exp_type.size() > 0) begin
                chk("attempt_type", 32'(cur_type), 32'(exp_type.pop_front()));
                chk("attempt_len", 32'(hi_cnt), 32'(exp_len.pop_front()));
            end
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, act as requesters and PHY
    task automatic step();
        @(posedge CLK);
        #1;
        phy_ack  = 1'b0;
        phy_nack = 1'b0;
        if (acked_last) chk("ack_to_done", 32'(done_hr | done_cr | done_msg), 32'd1);
        acked_last = 1'b0;
        if (done_hr)  begin hr_req  = 1'b0; log_done(0); end
        if (done_cr)  begin cr_req  = 1'b0; log_done(1); end
        if (done_msg) begin msg_req = 1'b0; log_done(2); end
        if (phy_req) begin
            if (!prev_req) begin
                n_pulses++;
                hi_cnt   = 0;
                cur_type = int'(phy_type);
                if (resp_kind.size() > 0) begin
                    cur_kind = resp_kind.pop_front();
                    cur_dly  = resp_dly.pop_front();
                end else begin
                    cur_kind = 2;
                end
            end
            hi_cnt++;
            if (cur_kind != 2 && hi_cnt == cur_dly) begin
                if (cur_kind == 0) begin
                    phy_ack    = 1'b1;
                    acked_last = 1'b1;
                end else begin
                    phy_nack = 1'b1;
                end
            end
        end else begin
            if (prev_req) attempt_end();
            if (stray_en && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) phy_ack = 1'b1;
                else phy_nack = 1'b1;
            end
        end
        prev_req = phy_req;
    endtask

    task automatic clear_alert();
        alert_clr = 16'hFFFF;
        step();
        alert_clr = 16'h0;
        m_alert   = 16'h0;
        chk("alert_clear_all", 32'(alert), 32'd0);
    endtask

    task automatic push_resp(input int kind, input int dly);
        resp_kind.push_back(kind);
        resp_dly.push_back(dly);
    endtask

    // Model: requesters served in priority order, consuming the response plan
    task automatic run_scenario(input bit h, input bit c, input bit m);
        int idx;
        int n;
        int maxatt;
        int first_type;
        bit ok;
        exp_type.delete();
        exp_len.delete();
        exp_done.delete();
        idx    = 0;
        maxatt = RETRY_EN ? 1 + RMAX : 1;
        if (h) begin
            exp_type.push_back(5);
            exp_len.push_back(resp_kind[idx] == 2 ? T : resp_dly[idx]);
            exp_done.push_back(0);
            m_alert |= (resp_kind[idx] == 0) ? 16'h0040 : 16'h0010;
            idx++;
        end
        if (c) begin
            exp_type.push_back(6);
            exp_len.push_back(resp_kind[idx] == 2 ? T : resp_dly[idx]);
            exp_done.push_back(1);
            m_alert |= (resp_kind[idx] == 0) ? 16'h0040 : 16'h0010;
            idx++;
        end
        if (m) begin
            n  = 0;
            ok = 1'b0;
            while (n < maxatt && !ok) begin
                exp_type.push_back(0);
                exp_len.push_back(resp_kind[idx] == 2 ? T : resp_dly[idx]);
                ok = (resp_kind[idx] == 0);
                idx++;
                n++;
            end
            exp_done.push_back(2);
            m_alert |= ok ? 16'h0040 : 16'h0010;
            exp_retry = RETRY_EN ? n - 1 : 0;
        end
        first_type = exp_type[0];
        hr_req  = h;
        cr_req  = c;
        msg_req = m;
        step();
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_req_early", 32'(phy_req), 32'd0);
        chk("grant_type", 32'(phy_type), 32'(first_type));
        step();
        chk("lat_req", 32'(phy_req), 32'd1);
        for (int i = 0; i < 2000 && (hr_req || cr_req || msg_req || busy); i++) step();
        phy_ack  = 1'b0;
        phy_nack = 1'b0;
        chk("scn_complete", 32'(hr_req | cr_req | msg_req | busy), 32'd0);
        chk("scn_attempts_left", 32'(exp_type.size()), 32'd0);
        chk("scn_dones_left", 32'(exp_done.size()), 32'd0);
        chk("scn_alert", 32'(alert), 32'(m_alert));
        resp_kind.delete();
        resp_dly.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_phy_req", 32'(phy_req), 32'd0);
        chk("rst_phy_type", 32'(phy_type), 32'd0);
        chk("rst_alert", 32'(alert), 32'd0);
        chk("rst_done", 32'({done_hr, done_cr, done_msg}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        reset = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Stray ack while idle is ignored
        phy_ack = 1'b1;
        step();
        step();
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_alert", 32'(alert), 32'd0);

        // Message acked 3 cycles after phy_req
        push_resp(0, 3);
        run_scenario(1'b0, 1'b0, 1'b1);
        chk("msg_ack_alert", 32'(alert), 32'h0040);

        // All three at once: HR, then CR, then message
        clear_alert();
        push_resp(0, 1); push_resp(0, 2); push_resp(0, 4);
        run_scenario(1'b1, 1'b1, 1'b1);

        // Message nacked on every attempt
        clear_alert();
        n_pulses = 0;
        for (int i = 0; i < 6; i++) push_resp(1, 2);
        run_scenario(1'b0, 1'b0, 1'b1);
        chk("nack_pulses", 32'(n_pulses), RETRY_EN ? 32'd4 : 32'd1);
        chk("nack_alert", 32'(alert), 32'h0010);

        // Cable Reset with a silent PHY times out
        clear_alert();
        push_resp(2, 0);
        run_scenario(1'b0, 1'b1, 1'b0);
        chk("cr_timeout_alert", 32'(alert), 32'h0010);

        // Hard Reset preempts a message in WAIT; clear of bit 5 in the same cycle loses
        clear_alert();
        track = 1'b0;
        push_resp(2, 0);
        push_resp(0, 2);
        msg_req = 1'b1;
        for (int i = 0; i < 20 && !(phy_req && hi_cnt == 2); i++) step();
        chk("pre_reached_wait", 32'(phy_req && hi_cnt == 2), 32'd1);
        hr_req    = 1'b1;
        alert_clr = 16'h0020;
        step();
        alert_clr = 16'h0;
        chk("pre_phy_req_drop", 32'(phy_req), 32'd0);
        chk("pre_done_msg", 32'(done_msg), 32'd1);
        chk("pre_alert5", 32'(alert[5]), 32'd1);
        chk("pre_idle", 32'(busy), 32'd0);
        step();
        chk("pre_hr_type", 32'(phy_type), 32'h5);
        chk("pre_hr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 200 && (hr_req || busy); i++) step();
        chk("pre_hr_complete", 32'(hr_req | busy), 32'd0);
        chk("pre_alert", 32'(alert), 32'h0060);
        alert_clr = 16'h0040;
        step();
        alert_clr = 16'h0;
        chk("partial_clear", 32'(alert), 32'h0020);
        resp_kind.delete();
        resp_dly.delete();

        // Reset mid-transfer aborts with no report
        push_resp(2, 0);
        msg_req = 1'b1;
        for (int i = 0; i < 10 && !phy_req; i++) step();
        chk("rmid_reached_wait", 32'(phy_req), 32'd1);
        reset   = 1'b0;
        msg_req = 1'b0;
        step();
        chk("rmid_phy_req", 32'(phy_req), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_done", 32'(done_msg), 32'd0);
        chk("rmid_alert", 32'(alert), 32'd0);
        reset = 1'b1;
        step();
        step();
        chk("rmid_after_busy", 32'(busy), 32'd0);
        chk("rmid_after_done", 32'({done_hr, done_cr, done_msg}), 32'd0);
        m_alert = 16'h0;
        track   = 1'b1;
        resp_kind.delete();
        resp_dly.delete();

        // Randomized scenarios
        for (int it = 0; it < 30; it++) begin
            bit h, c, m;
            int k;
            if (it % 4 == 0) clear_alert();
            h = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            if (!h && !c && !m) m = 1'b1;
            for (int j = 0; j < 6; j++) begin
                k = ($urandom_range(0, 9) < 2) ? 2 : int'($urandom_range(0, 1));
                push_resp(k, int'($urandom_range(1, T)));
            end
            stray_en = 1'($urandom_range(0, 1));
            run_scenario(h, c, m);
            stray_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
